// File: rtl/interrupt_sequencer.sv
// Priority-nested interrupt sequencer: synchronises/edge-detects request lines, arbitrates by
// fixed priority (highest index wins) and keeps an {id, return-pc} stack for nested handlers.
module interrupt_sequencer #(
    parameter int               WIDTH      = 32,
    parameter int               NUM_SRC    = 3,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010,
    localparam int              ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int              DEPTH_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               halt,
    input  logic               irq_take,
    input  logic [WIDTH-1:0]   ret_pc,
    input  logic               irq_ret,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [WIDTH-1:0]   irq_vec,
    output logic [WIDTH-1:0]   epc,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_err
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               stack_err_q, stack_err_d;
    logic [ID_W-1:0]    id_q [NUM_SRC];
    logic [ID_W-1:0]    id_d [NUM_SRC];
    logic [WIDTH-1:0]   pc_q [NUM_SRC];
    logic [WIDTH-1:0]   pc_d [NUM_SRC];

    logic [NUM_SRC-1:0] src_edge, cand;
    logic [ID_W-1:0]    top_id, win_id;
    logic               do_take, do_push, do_ret;

    assign src_edge = sync2_q & ~prev_q;

    // Top-of-stack lookup; entry depth-1 is the most recently pushed handler.
    always_comb begin
        top_id = '0;
        epc    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_id = id_q[i];
                epc    = pc_q[i];
            end
        end
    end

    always_comb begin
        cand   = '0;
        win_id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = pending_q[i] & src_en[i] & ((depth_q == '0) | (ID_W'(i) > top_id));
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i]) win_id = ID_W'(i);
        end
        irq_req = (|cand) & ~halt;
        irq_id  = irq_req ? win_id : '0;
        irq_vec = irq_req ? (VEC_BASE + WIDTH'(win_id) * VEC_STRIDE) : '0;
    end

    assign do_ret  = irq_ret & (depth_q != '0);
    assign do_take = irq_take & irq_req & ~irq_ret;
    assign do_push = do_take & (depth_q != DEPTH_W'(NUM_SRC));

    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        depth_d      = depth_q;
        id_d         = id_q;
        pc_d         = pc_q;
        stack_err_d  = stack_err_q
                     | (irq_ret & (depth_q == '0))
                     | (irq_take & irq_ret)
                     | (do_take & ~do_push);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (do_push && (win_id == ID_W'(i))) begin
                pending_d[i]    = 1'b0;
                in_service_d[i] = 1'b1;
            end
            if (do_push && (depth_q == DEPTH_W'(i))) begin
                id_d[i] = win_id;
                pc_d[i] = ret_pc;
            end
            if (do_ret && (top_id == ID_W'(i))) in_service_d[i] = 1'b0;
        end
        // A fresh edge in the same cycle as the take must not be lost.
        pending_d = pending_d | src_edge;
        if (do_push)     depth_d = depth_q + DEPTH_W'(1);
        else if (do_ret) depth_d = depth_q - DEPTH_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            depth_q      <= '0;
            stack_err_q  <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                id_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            sync1_q      <= src_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            depth_q      <= depth_d;
            stack_err_q  <= stack_err_d;
            id_q         <= id_d;
            pc_q         <= pc_d;
        end
    end

    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign depth      = depth_q;
    assign stack_err  = stack_err_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Multi-source, priority-nested interrupt controller for the single-cycle RISC-V CPU.
- Synchronises and edge-detects external request lines (board buttons/timers) and holds them as pending bits.
- Arbitrates the pending bits by fixed priority and presents a vector to the CPU's PC-next mux.
- Keeps a return-address/ID stack so higher-priority sources can preempt lower ones; the CPU returns with uret.

Parameters:
- WIDTH, 32, datapath/PC width.
- NUM_SRC, 3, number of interrupt sources; also the stack depth.
- VEC_BASE, 32'h0000_0100, handler address for source 0.
- VEC_STRIDE, 32'h0000_0010, address distance between consecutive source handlers.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- src_in  input  NUM_SRC  raw asynchronous request lines; a rising edge requests service.
- src_en  input  NUM_SRC  per-source mask; 1 = may be granted.
- halt  input  1  CPU halted; suppresses irq_req.
- irq_take  input  1  CPU redirects the PC to irq_vec on this cycle's clock edge.
- ret_pc  input  WIDTH  address to resume at (the CPU's PCNext), sampled with irq_take.
- irq_ret  input  1  uret executing; pops the stack.
- irq_req  output  1  an interrupt is ready to be taken.
- irq_id  output  $clog2(NUM_SRC)  winning source index.
- irq_vec  output  WIDTH  handler address for irq_id.
- epc  output  WIDTH  return address at the top of the stack.
- pending  output  NUM_SRC  latched pending bits.
- in_service  output  NUM_SRC  sources currently on the stack.
- depth  output  $clog2(NUM_SRC+1)  stack occupancy.
- stack_err  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous): all sync flops, pending, in_service, depth, stack entries and stack_err are 0. Consequently irq_req=0, irq_id=0, irq_vec=0 and epc=0.
- Input synchronisation: 2-flop synchroniser per source, then a registered previous value. edge[i] = sync2[i] & ~prev[i].
  - src_in rising before edge k → pending[i] is set at edge k+2.
  - Levels held high do not retrigger. A repeat edge while pending is already set is absorbed (no counting).
- Arbitration (combinational from registered state):
  - cand[i] = pending[i] & src_en[i] & (i > top_id, or depth==0).
  - Highest index wins: source NUM_SRC-1 has the highest priority.
  - irq_req = |cand & ~halt.
  - irq_id = winner index. irq_vec = VEC_BASE + irq_id*VEC_STRIDE, computed at WIDTH bits with wrap-around.
  - When irq_req=0: irq_id=0 and irq_vec=0.
- Take: irq_take while irq_req=1 and irq_ret=0 does the following at the clock edge:
  - push {irq_id, ret_pc}; depth+1;
  - clear pending[irq_id]; set in_service[irq_id].
  - The outputs reflect the new top on the following cycle.
- irq_take while irq_req=0: ignored, no state change.
- Return: irq_ret with depth>0 does the following:
  - pop; depth-1; clear in_service[popped id].
  - epc shows the new top entry, or 0 when depth becomes 0.
  - Lower pending sources are re-arbitrated on the next cycle.
- irq_ret with depth==0: ignored; stack_err set.
- Simultaneous irq_take and irq_ret: the ret is performed, the take is ignored (no push, pending kept), and stack_err is set. The CPU must never issue both.
- Edge detected on source i in the same cycle it is taken: the clear and the set collide and the set wins, so pending[i] stays 1. That source is then re-requested after its return, once it is no longer top_id.
- Overflow: strict-greater preemption bounds depth to NUM_SRC; depth never exceeds NUM_SRC. A push attempted at full depth is dropped and sets stack_err (defensive).
- src_en low: pending still latches but the source is not granted. Re-enabling later makes it eligible immediately.
- halt=1: pending still latches; irq_req is forced to 0.
- stack_err is cleared only by rst.

Test Plan:
- Reset: rst=1 mid-operation with depth=2 → next cycle depth=0, pending=0, epc=0, irq_req=0, stack_err=0.
- Single source: pulse src_in[0] before edge k → pending=3'b001 after edge k+2, irq_req=1, irq_vec=0x100. Take with ret_pc=0x40 → pending=0, depth=1, epc=0x40, irq_req=0.
- Nesting:
  - Source 0 in service (epc=0x40); pulse src_in[2] → irq_vec=0x120. Take with ret_pc=0x108 → depth=2, epc=0x108.
  - irq_ret → epc=0x40, depth=1. irq_ret again → depth=0.
- Priority and no preemption:
  - src_in[1] and src_in[2] pulsed together → irq_id=2 first. After the take, source 1 remains pending with irq_req=0.
  - After the ret, irq_id=1 and irq_vec=0x110.
- Mask/halt: src_en=3'b110 and src_in[0] pulsed → pending[0]=1, irq_req=0. Set src_en[0]=1 with halt=1 → irq_req=0. Clear halt → irq_req=1.
- Errors:
  - irq_ret at depth 0 → stack_err=1, depth=0.
  - irq_take with irq_req=0 → no state change.
  - irq_take and irq_ret together at depth 1 → depth=0, pending unchanged, stack_err=1.
